// File: rtl/execute_pkg.sv
// Shared constants and types for the execute stage: branch-condition codes,
// FSM state encoding, ALU operation encoding and the result sideband bundle.
package execute_pkg;

    // Branch-condition codes carried on br_cond
    localparam int BR_NONE = 0;
    localparam int BR_EQZ  = 1;
    localparam int BR_NEZ  = 2;
    localparam int BR_LTZ  = 3;
    localparam int BR_GEZ  = 4;

    // Execute-stage FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    // ALU operation encoding on oper; operand inversion and carry-in are
    // separate controls, so SUB is ADD with inv_b=1, cin=1.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_AND   = 4'd1,
        ALU_OR    = 4'd2,
        ALU_XOR   = 4'd3,
        ALU_SLL   = 4'd4,
        ALU_SRL   = 4'd5,
        ALU_SRA   = 4'd6,
        ALU_SLT   = 4'd7,
        ALU_PASSB = 4'd8
    } alu_op_e;

    // Single-bit sideband that travels with a result into the EX/MEM register
    typedef struct packed {
        logic mem_wr;
        logic mem_rd;
        logic halt;
        logic redirect;
    } side_t;

endpackage

// File: rtl/exe_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W
// cycles per product, low DATA_W bits only. done is asserted during the last
// busy cycle together with the final product so the caller can register it
// on that same edge.
module exe_mul_seq
    import execute_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] w_acc_next;

    // Partial product including the multiplier bit examined this cycle
    assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);

    // Iteration state: load on start, shift one bit per busy cycle, stop on abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (abort) begin
            r_busy <= 1'b0;
        end else if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_busy && (r_cnt == LAST);
    assign product = w_acc_next;

endmodule

// File: rtl/execute_pipe.sv
// Execute stage: ALU, branch/jump target and EX/MEM output register with a
// valid/ready handshake and flush. Multiplies run on exe_mul_seq and stall
// decode (in_ready=0) until the product lands in the output register.
module execute_pipe
    import execute_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MUL_EN = 1,
    parameter int BR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              b_src,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] br_off,
    input  logic [BR_W-1:0]   br_cond,
    input  logic              alu_jmp,
    input  logic [3:0]        oper,
    input  logic              inv_a,
    input  logic              inv_b,
    input  logic              cin,
    input  logic              sign,
    input  logic              mul_req,
    input  logic              halt,
    input  logic              mem_wr,
    input  logic              mem_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] pc_next,
    output logic              redirect,
    output logic              mem_wr_q,
    output logic              mem_rd_q,
    output logic              halt_q,
    output logic [DATA_W-1:0] pc_q
);

    localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [0:0]        r_state;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] r_pc_next;
    logic [DATA_W-1:0] r_pc_q;
    side_t             r_side;

    // Sideband of the multiply in flight, captured when it was accepted
    logic [DATA_W-1:0] r_mul_pc;
    logic [DATA_W-1:0] r_mul_pc_next;
    side_t             r_mul_side;

    logic [DATA_W-1:0] w_b_sel;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [SH_W-1:0]   w_shamt;
    logic              w_lt;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_z;
    logic              w_s;
    logic              w_taken;
    logic [DATA_W-1:0] w_pc_next;
    side_t             w_side;
    logic              w_in_ready;
    logic              w_load_en;
    logic              w_accept;
    logic              w_mul_start;
    logic              w_mul_busy;
    logic              w_mul_done_raw;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_product;

    // Operand selection and ALU input conditioning
    assign w_b_sel = b_src ? imm : rt_data;
    assign w_a     = inv_a ? ~rs_data : rs_data;
    assign w_b     = inv_b ? ~w_b_sel : w_b_sel;
    assign w_shamt = w_b[SH_W-1:0];
    assign w_lt    = sign ? ($signed(w_a) < $signed(w_b)) : (w_a < w_b);

    // ALU result for the current instruction
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_alu_res = '0;
        case (oper)
            ALU_ADD:   w_alu_res = w_a + w_b + DATA_W'(cin);
            ALU_AND:   w_alu_res = w_a & w_b;
            ALU_OR:    w_alu_res = w_a | w_b;
            ALU_XOR:   w_alu_res = w_a ^ w_b;
            ALU_SLL:   w_alu_res = w_a << w_shamt;
            ALU_SRL:   w_alu_res = w_a >> w_shamt;
            ALU_SRA:   w_alu_res = DATA_W'($signed(w_a) >>> w_shamt);
            ALU_SLT:   w_alu_res = DATA_W'(w_lt);
            ALU_PASSB: w_alu_res = w_b;
            default:   w_alu_res = '0;
        endcase
    end

    // Zero and sign flags of operand A drive the branch decision
    assign w_z = (rs_data == '0);
    assign w_s = rs_data[DATA_W-1];

    // Branch condition evaluation; halt forces not-taken
    always_comb begin
        w_taken = 1'b0;
        case (br_cond)
            BR_W'(BR_NONE): w_taken = 1'b0;
            BR_W'(BR_EQZ):  w_taken = w_z;
            BR_W'(BR_NEZ):  w_taken = !w_z;
            BR_W'(BR_LTZ):  w_taken = w_s;
            BR_W'(BR_GEZ):  w_taken = !w_s;
            default:        w_taken = 1'b0;
        endcase
        if (halt) begin
            w_taken = 1'b0;
        end
    end

    // Next PC: jump-register beats branch; sums wrap at DATA_W bits
    assign w_pc_next = alu_jmp ? w_alu_res : (w_taken ? pc + br_off : pc);

    assign w_side.mem_wr   = mem_wr;
    assign w_side.mem_rd   = mem_rd;
    assign w_side.halt     = halt;
    assign w_side.redirect = alu_jmp | w_taken;

    // Handshake: the output register can take new data when empty or draining
    assign w_load_en   = !r_out_valid || out_ready;
    assign w_in_ready  = (r_state == ST_IDLE) && w_load_en;
    assign w_accept    = in_valid && w_in_ready && !flush;
    assign w_mul_start = w_accept && mul_req && (MUL_EN != 0);
    assign w_mul_done  = (r_state == ST_MUL) && w_mul_busy && w_mul_done_raw;

    exe_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .abort   (flush),
        .a       (rs_data),
        .b       (w_b_sel),
        .busy    (w_mul_busy),
        .done    (w_mul_done_raw),
        .product (w_product)
    );

    // FSM: IDLE until a multiply is accepted, back to IDLE on completion or flush
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_mul_start) r_state <= ST_MUL;
                ST_MUL:  if (flush || w_mul_done) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Capture the multiply's sideband at accept time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_pc      <= '0;
            r_mul_pc_next <= '0;
            r_mul_side    <= '0;
        end else if (w_mul_start) begin
            r_mul_pc      <= pc;
            r_mul_pc_next <= w_pc_next;
            r_mul_side    <= w_side;
        end
    end

    // EX/MEM register: flush squashes, product or ALU result loads, else drain or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_pc_next   <= '0;
            r_pc_q      <= '0;
            r_side      <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_alu_out   <= w_product;
            r_pc_next   <= r_mul_pc_next;
            r_pc_q      <= r_mul_pc;
            r_side      <= r_mul_side;
        end else if (w_accept && !w_mul_start) begin
            r_out_valid <= 1'b1;
            r_alu_out   <= w_alu_res;
            r_pc_next   <= w_pc_next;
            r_pc_q      <= pc;
            r_side      <= w_side;
        end else if (w_load_en) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign alu_out   = r_alu_out;
    assign pc_next   = r_pc_next;
    assign pc_q      = r_pc_q;
    assign redirect  = r_side.redirect;
    assign mem_wr_q  = r_side.mem_wr;
    assign mem_rd_q  = r_side.mem_rd;
    assign halt_q    = r_side.halt;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed self-checking bench for execute_pipe (DATA_W=16, MUL_EN=1).
module tb_execute_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic        b_src;
    logic [15:0] pc;
    logic [15:0] br_off;
    logic [3:0]  br_cond;
    logic        alu_jmp;
    logic [3:0]  oper;
    logic        inv_a;
    logic        inv_b;
    logic        cin;
    logic        sign;
    logic        mul_req;
    logic        halt;
    logic        mem_wr;
    logic        mem_rd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_out;
    logic [15:0] pc_next;
    logic        redirect;
    logic        mem_wr_q;
    logic        mem_rd_q;
    logic        halt_q;
    logic [15:0] pc_q;

    int n_chk  = 0;
    int n_fail = 0;

    execute_pipe #(
        .DATA_W (16),
        .MUL_EN (1),
        .BR_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .imm       (imm),
        .b_src     (b_src),
        .pc        (pc),
        .br_off    (br_off),
        .br_cond   (br_cond),
        .alu_jmp   (alu_jmp),
        .oper      (oper),
        .inv_a     (inv_a),
        .inv_b     (inv_b),
        .cin       (cin),
        .sign      (sign),
        .mul_req   (mul_req),
        .halt      (halt),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .pc_next   (pc_next),
        .redirect  (redirect),
        .mem_wr_q  (mem_wr_q),
        .mem_rd_q  (mem_rd_q),
        .halt_q    (halt_q),
        .pc_q      (pc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; rs_data = '0; rt_data = '0; imm = '0;
        b_src = 1'b0; pc = '0; br_off = '0; br_cond = 4'd0; alu_jmp = 1'b0;
        oper = 4'd0; inv_a = 1'b0; inv_b = 1'b0; cin = 1'b0; sign = 1'b0;
        mul_req = 1'b0; halt = 1'b0; mem_wr = 1'b0; mem_rd = 1'b0;
    endtask

    // Present a plain ADD of a and b at program counter p
    task automatic drive_add(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p);
        idle_inputs();
        in_valid = 1'b1; rs_data = a; rt_data = b; pc = p; oper = 4'd0;
    endtask

    initial begin
        int n;
        idle_inputs();
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_out", alu_out, 0);
        check("rst_pc_next", pc_next, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // ADD 3+4
        drive_add(16'h0003, 16'h0004, 16'h0100);
        #1 check("add_in_ready", in_ready, 1);
        tick();
        check("add_out_valid", out_valid, 1);
        check("add_alu_out", alu_out, 16'h0007);
        check("add_redirect", redirect, 0);
        check("add_pc_next", pc_next, 16'h0100);

        // BR_EQZ taken with negative offset
        idle_inputs();
        in_valid = 1'b1; rs_data = 16'h0000; pc = 16'h0010; br_off = 16'hFFF8; br_cond = 4'd1;
        tick();
        check("eqz_pc_next", pc_next, 16'h0008);
        check("eqz_redirect", redirect, 1);

        // Same branch with halt: suppressed
        halt = 1'b1;
        tick();
        check("eqz_halt_pc_next", pc_next, 16'h0010);
        check("eqz_halt_redirect", redirect, 0);
        check("eqz_halt_q", halt_q, 1);

        // BR_LTZ on a negative operand
        idle_inputs();
        in_valid = 1'b1; rs_data = 16'h8000; pc = 16'h0020; br_off = 16'h0004; br_cond = 4'd3;
        tick();
        check("ltz_pc_next", pc_next, 16'h0024);
        check("ltz_alu_out", alu_out, 16'h8000);

        // BR_GEZ on the same negative operand: not taken
        br_cond = 4'd4;
        tick();
        check("gez_pc_next", pc_next, 16'h0020);
        check("gez_redirect", redirect, 0);

        // SUB 5-7 via inv_b/cin, with mem_wr passthrough
        idle_inputs();
        in_valid = 1'b1; rs_data = 16'h0005; rt_data = 16'h0007; inv_b = 1'b1; cin = 1'b1;
        mem_wr = 1'b1; pc = 16'h0030;
        tick();
        check("sub_alu_out", alu_out, 16'hFFFE);
        check("sub_mem_wr_q", mem_wr_q, 1);

        // Jump register: target = rs + imm
        idle_inputs();
        in_valid = 1'b1; rs_data = 16'h0040; imm = 16'h0004; b_src = 1'b1; alu_jmp = 1'b1;
        pc = 16'h0050;
        tick();
        check("jr_pc_next", pc_next, 16'h0044);
        check("jr_redirect", redirect, 1);

        // Stall: result held for 3 cycles while out_ready=0
        drive_add(16'h1111, 16'h2222, 16'h0060);
        tick();
        check("stall_first", alu_out, 16'h3333);
        drive_add(16'h0001, 16'h0001, 16'h0064);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_in_ready", in_ready, 0);
            tick();
            check("stall_alu_held", alu_out, 16'h3333);
            check("stall_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        #1 check("stall_release_ready", in_ready, 1);
        tick();
        check("stall_next_alu", alu_out, 16'h0002);
        check("stall_next_pc", pc_q, 16'h0064);
        idle_inputs();
        tick();
        check("drain_valid", out_valid, 0);

        // Multiply 0x12 * 0x34
        idle_inputs();
        in_valid = 1'b1; mul_req = 1'b1; rs_data = 16'h0012; rt_data = 16'h0034;
        mem_rd = 1'b1; pc = 16'h0200;
        #1 check("mul_accept_ready", in_ready, 1);
        tick();
        idle_inputs();
        n = 0;
        while (!in_ready && n < 40) begin
            if (out_valid) check("mul_early_valid", out_valid, 0);
            n++;
            tick();
        end
        check("mul_busy_cycles", n, 16);
        check("mul_out_valid", out_valid, 1);
        check("mul_product", alu_out, 16'h03A8);
        check("mul_mem_rd_q", mem_rd_q, 1);
        check("mul_pc_q", pc_q, 16'h0200);
        tick();
        check("mul_drain", out_valid, 0);

        // Flush in the 5th multiply cycle: no result ever emitted
        idle_inputs();
        in_valid = 1'b1; mul_req = 1'b1; rs_data = 16'h0003; rt_data = 16'h0005;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_out_valid", out_valid, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) n++;
            tick();
        end
        check("flush_no_result", n, 0);

        // Flush wins over a simultaneous accept
        drive_add(16'h0009, 16'h0001, 16'h0070);
        flush = 1'b1;
        tick();
        idle_inputs();
        check("flush_accept_dropped", out_valid, 0);

        // Async reset while an output is held
        drive_add(16'h0010, 16'h0020, 16'h0300);
        mem_wr = 1'b1;
        tick();
        idle_inputs();
        out_ready = 1'b0;
        tick();
        check("held_alu", alu_out, 16'h0030);
        rst = 1'b1;
        #1;
        check("rst_held_valid", out_valid, 0);
        check("rst_held_alu", alu_out, 0);
        check("rst_held_pc_q", pc_q, 0);
        check("rst_held_mem_wr", mem_wr_q, 0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Async reset mid-multiply, previous result still on alu_out
        drive_add(16'h0011, 16'h0022, 16'h0400);
        tick();
        idle_inputs();
        in_valid = 1'b1; mul_req = 1'b1; rs_data = 16'h0007; rt_data = 16'h0009; pc = 16'h0404;
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();
        check("mid_mul_busy", in_ready, 0);
        rst = 1'b1;
        #1;
        check("rst_mul_alu", alu_out, 0);
        check("rst_mul_pc_next", pc_next, 0);
        check("rst_mul_in_ready", in_ready, 1);
        #2 rst = 1'b0;
        tick();

        // First accept after reset behaves like the plain ADD
        drive_add(16'h0003, 16'h0004, 16'h0100);
        tick();
        idle_inputs();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_alu", alu_out, 16'h0007);
        check("post_rst_pc_next", pc_next, 16'h0100);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) n++;
        end
        check("post_rst_no_stale", n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
